fp_addsub_align_stage: RTL and testbench
========================================

# fp_addsub_align_stage

Parametrised first stage of the floating-point add/subtract pipeline. It unpacks two IEEE-754-style operands, applies the operation to B's sign, and orders the operands by full magnitude so the larger is always "big". It computes the alignment shift, classifies NaN and Inf, and short-circuits special results. It replaces the fixed 32-bit compare stage and adds a valid/ready handshake so the downstream align/add stages can stall it.

## Interface
Parameters:
- EXP_W, 8, exponent width.
- MAN_W, 23, stored fraction width. Total word W = 1+EXP_W+MAN_W.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  stage can accept a beat.
- a, b  in  W  operands.
- op  in  1  0 = add (a+b), 1 = subtract (a−b).
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts.
- sign_big, sign_small  out  1  signs of the ordered operands; sign_small is the effective sign (b's sign XOR op when b is small).
- eff_sub  out  1  sign_big XOR sign_small.
- exp_big  out  EXP_W  effective exponent of the big operand.
- exp_diff  out  EXP_W  exp_big − effective exponent of small.
- shift_sat  out  1  exp_diff > MAN_W+3; small operand collapses to sticky.
- man_big, man_small  out  MAN_W+1  mantissas with hidden bit.
- swapped  out  1  b was the larger magnitude.
- special_valid  out  1  special_result is final; downstream bypasses arithmetic.
- special_result  out  W  final result for the NaN/Inf cases.
- invalid  out  1  IEEE invalid-operation flag.

## Operation
- Unpack per operand:
  - exp==0: hidden bit 0, effective exponent 1 (denormal).
  - Otherwise: hidden bit 1, effective exponent = exp.
- Apply op: b_sign_eff = b[W-1] ^ op.
- Magnitude order: compare {eff_exp, mantissa} as one unsigned key.
  - swapped = key_b > key_a.
  - Equal keys give swapped=0.
  - The big operand's fields drive the *_big outputs. sign_small takes the other operand's (effective) sign.
- Special cases, in priority order:
  1. Either operand NaN (exp all ones, fraction ≠0): special_result = canonical qNaN (sign 0, exp all ones, fraction MSB 1, rest 0). invalid=1 only if the NaN is signalling (fraction MSB 0).
  2. Both Inf and eff_sub: canonical qNaN, invalid=1.
  3. One or both Inf: special_result = Inf carrying the sign of the Inf operand (effective sign for b).
  4. Otherwise special_valid=0 and special_result=0.
- Zeros and denormals are not special; they go through the normal datapath.
- All datapath outputs are registered together with out_valid.

## Timing
- Latency: 1 cycle from accepted input (in_valid & in_ready) to out_valid.
- Throughput: 1 beat/cycle while out_ready=1.
- Handshake:
  - Transfer occurs on valid & ready.
  - out_valid and the data outputs hold stable until out_ready.
  - in_valid may drop without a transfer.
- Reset (async):
  - out_valid=0, all data outputs 0.
  - in_ready=1 on the first cycle after reset release.
  - Reset during a stall discards every buffered beat; no beat is emitted afterwards.
- Beat order is preserved and no beat is ever dropped or duplicated.

## Configuration
- FP_ALIGN_SKID_EN defined:
  - Two-entry skid buffer (main + skid register). in_ready is a registered signal with no combinational path from out_ready.
  - in_ready deasserts the cycle after the skid entry fills. A beat accepted while out_ready is low parks in the skid entry.
- FP_ALIGN_SKID_EN undefined:
  - Single output register, in_ready = !out_valid | out_ready (combinational).
- Latency and results are identical in both builds.

## Structure
- Shared package fp_pkg holds:
  - EXP_W/MAN_W defaults.
  - Canonical qNaN construction.
  - The operand class enum (ZERO, DENORM, NORMAL, INF, QNAN, SNAN).
- Sub-module fp_unpack (combinational, parametrised) is instantiated once per operand. It produces sign, effective exponent, hidden-bit mantissa and class.

## Test plan
Defaults W=32; checks at out_valid.
- a=0x40400000, b=0x3F800000, op=0 → swapped=0, exp_big=0x80, exp_diff=1, man_big=0xC00000, man_small=0x800000, eff_sub=0, out_valid one cycle after accept.
- a=0x3F800000, b=0x40400000, op=1 → swapped=1, sign_big=1, sign_small=0, eff_sub=1, exp_diff=1.
- a=0x3F800001, b=0x3F800002, op=0 → exp_diff=0, swapped=1 (mantissa tiebreak); a=b → swapped=0.
- a=b=0x7F800000, op=1 → special_valid=1, special_result=0x7FC00000, invalid=1; a=0x7F800001 (sNaN) → 0x7FC00000, invalid=1.
- a=0x00000001, b=0x00800000 → exp_diff=0, swapped=1, man_big=0x800000, man_small=0x000001; a=0x4B000000, b=0x3F800000 → exp_diff=23, shift_sat=0; with b=0x33800000 → shift_sat=1.
- Backpressure:
  - out_ready=0, drive 3 beats back-to-back → skid build accepts 2, then in_ready=0 (non-skid accepts 1).
  - Release out_ready → beats emerge in order, unchanged.
  - Assert rst mid-stall → out_valid=0 next edge; no stale beat afterwards.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared floating-point definitions: default field widths, operand classes, canonical qNaN.
package fp_pkg;

  localparam int unsigned EXP_W_DEF = 8;
  localparam int unsigned MAN_W_DEF = 23;

  typedef enum logic [2:0] {
    FP_ZERO,
    FP_DENORM,
    FP_NORMAL,
    FP_INF,
    FP_QNAN,
    FP_SNAN
  } fp_class_e;

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set; caller truncates to word width.
  function automatic logic [63:0] qnan_word(input int unsigned exp_w, input int unsigned man_w);
    logic [63:0] r;
    r = ((64'd1 << exp_w) - 64'd1) << man_w;
    r = r | (64'd1 << (man_w - 1));
    return r;
  endfunction

endpackage

// File: rtl/fp_addsub_align_stage_if.sv
// Operand/result handshake bundle for the add/sub align stage.
interface fp_addsub_align_stage_if
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = EXP_W_DEF,
  parameter int unsigned MAN_W = MAN_W_DEF
);
  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             op;

  logic             out_valid;
  logic             out_ready;
  logic             sign_big;
  logic             sign_small;
  logic             eff_sub;
  logic [EXP_W-1:0] exp_big;
  logic [EXP_W-1:0] exp_diff;
  logic             shift_sat;
  logic [MAN_W:0]   man_big;
  logic [MAN_W:0]   man_small;
  logic             swapped;
  logic             special_valid;
  logic [W-1:0]     special_result;
  logic             invalid;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, sign_big, sign_small, eff_sub, exp_big, exp_diff,
           shift_sat, man_big, man_small, swapped, special_valid, special_result, invalid
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, sign_big, sign_small, eff_sub, exp_big, exp_diff,
           shift_sat, man_big, man_small, swapped, special_valid, special_result, invalid
  );

endinterface

// File: rtl/fp_unpack.sv
// Splits one operand into sign, effective exponent, hidden-bit mantissa and class.
module fp_unpack
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = EXP_W_DEF,
  parameter int unsigned MAN_W = MAN_W_DEF
) (
  input  logic [EXP_W+MAN_W:0] x,
  output logic                 sign,
  output logic [EXP_W-1:0]     exp_eff,
  output logic [MAN_W:0]       man,
  output fp_class_e            cls
);

  logic [EXP_W-1:0] exp_raw;
  logic [MAN_W-1:0] frac;
  logic             exp_zero;
  logic             exp_ones;
  logic             frac_zero;

  assign sign    = x[EXP_W+MAN_W];
  assign exp_raw = x[EXP_W+MAN_W-1 -: EXP_W];
  assign frac    = x[MAN_W-1:0];

  always_comb begin
    exp_zero  = (exp_raw == '0);
    exp_ones  = &exp_raw;
    frac_zero = (frac == '0);
    // Denormals share the exponent of the smallest normal, with no hidden bit.
    exp_eff   = exp_zero ? EXP_W'(1) : exp_raw;
    man       = {!exp_zero, frac};
    cls       = FP_NORMAL;
    if (exp_zero)      cls = frac_zero ? FP_ZERO : FP_DENORM;
    else if (exp_ones) cls = frac_zero ? FP_INF : (frac[MAN_W-1] ? FP_QNAN : FP_SNAN);
  end

endmodule

// File: rtl/fp_addsub_align_stage.sv
// First add/sub stage: unpack, magnitude-order, alignment shift, NaN/Inf bypass, registered handshake.
// Optional two-entry skid buffer with registered in_ready when FP_ALIGN_SKID_EN is defined.
module fp_addsub_align_stage
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = EXP_W_DEF,
  parameter int unsigned MAN_W = MAN_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  fp_addsub_align_stage_if.slave  bus
);

  localparam int unsigned W = 1 + EXP_W + MAN_W;
  localparam logic [W-1:0] QNAN    = W'(qnan_word(EXP_W, MAN_W));
  localparam logic [W-1:0] INF_MAG = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

  typedef struct packed {
    logic             sign_big;
    logic             sign_small;
    logic             eff_sub;
    logic [EXP_W-1:0] exp_big;
    logic [EXP_W-1:0] exp_diff;
    logic             shift_sat;
    logic [MAN_W:0]   man_big;
    logic [MAN_W:0]   man_small;
    logic             swapped;
    logic             special_valid;
    logic [W-1:0]     special_result;
    logic             invalid;
  } res_t;

  logic             sign_a, sign_b_raw, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W:0]   man_a, man_b;
  fp_class_e        cls_a, cls_b;

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
    .x(bus.a), .sign(sign_a), .exp_eff(exp_a), .man(man_a), .cls(cls_a)
  );

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
    .x(bus.b), .sign(sign_b_raw), .exp_eff(exp_b), .man(man_b), .cls(cls_b)
  );

  assign sign_b = sign_b_raw ^ bus.op;

  res_t       res_c;
  logic       swap;
  logic [EXP_W-1:0] exp_small;
  logic       nan_a, nan_b, inf_a, inf_b;

  // Order by full magnitude, then classify specials.
  always_comb begin
    res_c     = '0;
    swap      = {exp_b, man_b} > {exp_a, man_a};
    nan_a     = (cls_a == FP_QNAN) || (cls_a == FP_SNAN);
    nan_b     = (cls_b == FP_QNAN) || (cls_b == FP_SNAN);
    inf_a     = (cls_a == FP_INF);
    inf_b     = (cls_b == FP_INF);

    res_c.swapped    = swap;
    res_c.sign_big   = swap ? sign_b : sign_a;
    res_c.sign_small = swap ? sign_a : sign_b;
    res_c.eff_sub    = sign_a ^ sign_b;
    res_c.exp_big    = swap ? exp_b : exp_a;
    exp_small        = swap ? exp_a : exp_b;
    res_c.exp_diff   = res_c.exp_big - exp_small;
    res_c.shift_sat  = 32'(res_c.exp_diff) > 32'(MAN_W + 3);
    res_c.man_big    = swap ? man_b : man_a;
    res_c.man_small  = swap ? man_a : man_b;

    if (nan_a || nan_b) begin
      res_c.special_valid  = 1'b1;
      res_c.special_result = QNAN;
      res_c.invalid        = (cls_a == FP_SNAN) || (cls_b == FP_SNAN);
    end else if (inf_a && inf_b && res_c.eff_sub) begin
      res_c.special_valid  = 1'b1;
      res_c.special_result = QNAN;
      res_c.invalid        = 1'b1;
    end else if (inf_a) begin
      res_c.special_valid  = 1'b1;
      res_c.special_result = {sign_a, INF_MAG[W-2:0]};
    end else if (inf_b) begin
      res_c.special_valid  = 1'b1;
      res_c.special_result = {sign_b, INF_MAG[W-2:0]};
    end
  end

  res_t main_q, main_n;
  logic main_v, main_v_n;

`ifdef FP_ALIGN_SKID_EN
  res_t skid_q, skid_n;
  logic skid_v, skid_v_n;
  logic in_ready_q;
  logic accept, pop;

  // Main entry feeds the output; skid entry parks a beat accepted while the output stalls.
  always_comb begin
    main_n   = main_q;
    main_v_n = main_v;
    skid_n   = skid_q;
    skid_v_n = skid_v;
    accept   = bus.in_valid & in_ready_q;
    pop      = main_v & bus.out_ready;
    if (skid_v) begin
      if (pop) begin
        main_n   = skid_q;
        skid_v_n = 1'b0;
      end
    end else if (accept) begin
      if (!main_v || pop) begin
        main_n   = res_c;
        main_v_n = 1'b1;
      end else begin
        skid_n   = res_c;
        skid_v_n = 1'b1;
      end
    end else if (pop) begin
      main_v_n = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q     <= '0;
      main_v     <= 1'b0;
      skid_q     <= '0;
      skid_v     <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      main_q     <= main_n;
      main_v     <= main_v_n;
      skid_q     <= skid_n;
      skid_v     <= skid_v_n;
      in_ready_q <= !skid_v_n;
    end
  end

  assign bus.in_ready = in_ready_q;
`else
  logic in_ready_c;
  logic accept;

  assign in_ready_c = !main_v | bus.out_ready;

  always_comb begin
    main_n   = main_q;
    main_v_n = main_v;
    accept   = bus.in_valid & in_ready_c;
    if (accept) begin
      main_n   = res_c;
      main_v_n = 1'b1;
    end else if (bus.out_ready) begin
      main_v_n = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      main_v <= 1'b0;
    end else begin
      main_q <= main_n;
      main_v <= main_v_n;
    end
  end

  assign bus.in_ready = in_ready_c;
`endif

  assign bus.out_valid      = main_v;
  assign bus.sign_big       = main_q.sign_big;
  assign bus.sign_small     = main_q.sign_small;
  assign bus.eff_sub        = main_q.eff_sub;
  assign bus.exp_big        = main_q.exp_big;
  assign bus.exp_diff       = main_q.exp_diff;
  assign bus.shift_sat      = main_q.shift_sat;
  assign bus.man_big        = main_q.man_big;
  assign bus.man_small      = main_q.man_small;
  assign bus.swapped        = main_q.swapped;
  assign bus.special_valid  = main_q.special_valid;
  assign bus.special_result = main_q.special_result;
  assign bus.invalid        = main_q.invalid;

endmodule

// File: tb/tb_fp_addsub_align_stage.sv
// Scoreboard bench for fp_addsub_align_stage with hand-computed directed vectors (binary32).
module tb_fp_addsub_align_stage;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned W     = 32;

`ifdef FP_ALIGN_SKID_EN
  localparam int BP_ACC = 2;
`else
  localparam int BP_ACC = 1;
`endif

  typedef struct packed {
    logic        sign_big;
    logic        sign_small;
    logic        eff_sub;
    logic [7:0]  exp_big;
    logic [7:0]  exp_diff;
    logic        shift_sat;
    logic [23:0] man_big;
    logic [23:0] man_small;
    logic        swapped;
    logic        special_valid;
    logic [31:0] special_result;
    logic        invalid;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_addsub_align_stage_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

  fp_addsub_align_stage #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk(input logic sb, input logic ss, input logic es,
                              input logic [7:0] eb, input logic [7:0] ed, input logic sat,
                              input logic [23:0] mb, input logic [23:0] ms, input logic sw,
                              input logic spv, input logic [31:0] sr, input logic inv);
    exp_t e;
    e = '{sb, ss, es, eb, ed, sat, mb, ms, sw, spv, sr, inv};
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t g;
    g = '{bus.sign_big, bus.sign_small, bus.eff_sub, bus.exp_big, bus.exp_diff, bus.shift_sat,
          bus.man_big, bus.man_small, bus.swapped, bus.special_valid, bus.special_result,
          bus.invalid};
    return g;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Monitor: compare every transferred beat against the head of the scoreboard.
  initial begin
    exp_t g, e;
    forever begin
      @(negedge clk);
      #4;
      if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        g = observed();
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none", g);
        end else begin
          e = sb_q.pop_front();
          if (g !== e) begin
            errors++;
            $display("FAIL beat: got %0h expected %0h", g, e);
          end
        end
      end
    end
  end

  // Offer one beat until accepted (bounded); returns after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op, input exp_t e);
    bit ok;
    ok = 0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = a;
      bus.b        = b;
      bus.op       = op;
      #1;
      if (bus.in_ready) begin
        sb_q.push_back(e);
        ok = 1;
      end
      @(posedge clk);
    end
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 60 && sb_q.size() > 0; n++) @(posedge clk);
    #2;
    chk("drain", 128'(sb_q.size()), 0);
  endtask

  logic [31:0] bp_a[3];
  logic [31:0] bp_b[3];
  logic        bp_op[3];
  exp_t        bp_e[3];

  // Drive three back-to-back offer cycles while stalled; returns how many were accepted.
  task automatic burst(output int acc);
    acc = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = bp_a[acc];
      bus.b        = bp_b[acc];
      bus.op       = bp_op[acc];
      #1;
      if (bus.in_ready) begin
        sb_q.push_back(bp_e[acc]);
        acc++;
      end
      @(posedge clk);
    end
    idle();
  endtask

  initial begin
    int acc;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = 1'b0;
    bus.out_ready = 1'b1;

    bp_a[0] = 32'h40400000; bp_b[0] = 32'h3F800000; bp_op[0] = 1'b0;
    bp_e[0] = mk(0,0,0,8'h80,8'd1,0,24'hC00000,24'h800000,0,0,32'h0,0);
    bp_a[1] = 32'h3F800000; bp_b[1] = 32'h40400000; bp_op[1] = 1'b1;
    bp_e[1] = mk(1,0,1,8'h80,8'd1,0,24'hC00000,24'h800000,1,0,32'h0,0);
    bp_a[2] = 32'h3F800001; bp_b[2] = 32'h3F800002; bp_op[2] = 1'b0;
    bp_e[2] = mk(0,0,0,8'h7F,8'd0,0,24'h800002,24'h800001,1,0,32'h0,0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 128'(bus.out_valid), 0);
    chk("reset_data", 128'(observed()), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("in_ready_after_reset", 128'(bus.in_ready), 1);

    // First beat: out_valid exactly one cycle after accept.
    send(bp_a[0], bp_b[0], bp_op[0], bp_e[0]);
    idle();
    #1;
    chk("latency_out_valid", 128'(bus.out_valid), 1);
    @(negedge clk);
    #1;
    chk("out_valid_clears", 128'(bus.out_valid), 0);

    send(bp_a[1], bp_b[1], bp_op[1], bp_e[1]);
    send(bp_a[2], bp_b[2], bp_op[2], bp_e[2]);
    send(32'h3F800001, 32'h3F800001, 1'b0, mk(0,0,0,8'h7F,8'd0,0,24'h800001,24'h800001,0,0,32'h0,0));
    send(32'h7F800000, 32'h7F800000, 1'b1, mk(0,1,1,8'hFF,8'd0,0,24'h800000,24'h800000,0,1,32'h7FC00000,1));
    send(32'h7F800001, 32'h3F800000, 1'b0, mk(0,0,0,8'hFF,8'h80,1,24'h800001,24'h800000,0,1,32'h7FC00000,1));
    send(32'h00000001, 32'h00800000, 1'b0, mk(0,0,0,8'h01,8'd0,0,24'h800000,24'h000001,1,0,32'h0,0));
    send(32'h4B000000, 32'h3F800000, 1'b0, mk(0,0,0,8'h96,8'd23,0,24'h800000,24'h800000,0,0,32'h0,0));
    send(32'h4B000000, 32'h33800000, 1'b0, mk(0,0,0,8'h96,8'd47,1,24'h800000,24'h800000,0,0,32'h0,0));
    send(32'h4B000000, 32'h3E000000, 1'b0, mk(0,0,0,8'h96,8'd26,0,24'h800000,24'h800000,0,0,32'h0,0));
    send(32'h4B000000, 32'h3D800000, 1'b0, mk(0,0,0,8'h96,8'd27,1,24'h800000,24'h800000,0,0,32'h0,0));
    send(32'h3F800000, 32'hFFC00000, 1'b0, mk(1,0,1,8'hFF,8'h80,1,24'hC00000,24'h800000,1,1,32'h7FC00000,0));
    send(32'h3F800000, 32'h7F800000, 1'b1, mk(1,0,1,8'hFF,8'h80,1,24'h800000,24'h800000,1,1,32'hFF800000,0));
    send(32'hFF800000, 32'h7F800000, 1'b1, mk(1,1,0,8'hFF,8'd0,0,24'h800000,24'h800000,0,1,32'hFF800000,0));
    send(32'h00000000, 32'h00000000, 1'b1, mk(0,1,1,8'h01,8'd0,0,24'h000000,24'h000000,0,0,32'h0,0));
    idle();
    wait_drain();

    // Backpressure: stalled output, three offered beats.
    @(negedge clk);
    bus.out_ready = 1'b0;
    burst(acc);
    #1;
    chk("bp_accepted", 128'(acc), 128'(BP_ACC));
    chk("bp_in_ready_low", 128'(bus.in_ready), 0);
    chk("bp_out_valid_held", 128'(bus.out_valid), 1);
    chk("bp_head_stable", 128'(observed()), 128'(bp_e[0]));
    @(negedge clk);
    bus.out_ready = 1'b1;
    wait_drain();

    // Reset during a stall discards all buffered beats.
    @(negedge clk);
    bus.out_ready = 1'b0;
    burst(acc);
    #2;
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk);
    #1;
    chk("rst_stall_out_valid", 128'(bus.out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_stall_in_ready", 128'(bus.in_ready), 1);
    repeat (8) @(posedge clk);
    #1;
    chk("no_stale_beat", 128'(bus.out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
